// File: rtl/apb_uart_fifo.sv
// ---------------------------------------------------------------------------
// apb_uart_fifo
//   APB-attached UART with a TX FIFO and an RX FIFO. Software pushes
//   characters through DATA, reads received characters back through DATA,
//   watches flags in STATUS, configures the line in CTRL and sets the bit
//   period in BAUD_DIV (bit period = BAUD_DIV+1 pclk cycles).
//
//   Ports
//     pclk, prst          single clock, asynchronous active-high reset
//     paddr .. pwdata     APB request (only paddr[3:2] decoded)
//     pready, prdata,     APB response (zero wait states)
//     pslverr
//     rx                  serial input, asynchronous to pclk
//     tx                  serial output, idle high
//     uart_irq            registered level interrupt
// ---------------------------------------------------------------------------
module apb_uart_fifo #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUDRATE    = 9600
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic                  rx,
  output logic                  tx,
  output logic                  uart_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = 3;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [15:0]   RESET_DIV = 16'(CLK_FREQ_HZ / BAUDRATE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uartState_t;

  // -------------------------------------------------------------------------
  // Configuration and sticky status registers
  // -------------------------------------------------------------------------
  logic [5:0]  r_ctrl;
  logic [15:0] r_baudDiv;
  logic        r_parityErr;
  logic        r_frameErr;
  logic        r_overrun;
  logic        r_irq;

  logic w_txEn, w_rxEn, w_parityEn, w_parityOdd, w_rxIrqEn, w_txIrqEn;
  assign w_txEn      = r_ctrl[0];
  assign w_rxEn      = r_ctrl[1];
  assign w_parityEn  = r_ctrl[2];
  assign w_parityOdd = r_ctrl[3];
  assign w_rxIrqEn   = r_ctrl[4];
  assign w_txIrqEn   = r_ctrl[5];

  // -------------------------------------------------------------------------
  // APB decode
  // -------------------------------------------------------------------------
  logic w_access, w_wr, w_rd;
  logic w_selData, w_selStatus, w_selCtrl, w_selBaud;
  assign w_access    = pselx & penable;
  assign w_wr        = w_access & pwrite;
  assign w_rd        = w_access & ~pwrite;
  assign w_selData   = (paddr[3:2] == 2'd0);
  assign w_selStatus = (paddr[3:2] == 2'd1);
  assign w_selCtrl   = (paddr[3:2] == 2'd2);
  assign w_selBaud   = (paddr[3:2] == 2'd3);
  assign pready      = 1'b1;

  logic w_unused;
  assign w_unused = ^{paddr[ADDR_WIDTH-1:4], paddr[1:0], pwdata[31:16]};

  // -------------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit so full and empty are exact
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_txMem [FIFO_DEPTH];
  logic [PW:0]           r_txWptr, r_txRptr;
  logic                  w_txEmpty, w_txFull, w_txPush, w_txPushReq, w_txPop;
  logic [DATA_WIDTH-1:0] w_txHead;

  assign w_txEmpty   = (r_txWptr == r_txRptr);
  assign w_txFull    = (r_txWptr[PW] != r_txRptr[PW]) &&
                       (r_txWptr[PW-1:0] == r_txRptr[PW-1:0]);
  assign w_txHead    = r_txMem[r_txRptr[PW-1:0]];
  assign w_txPushReq = w_wr & w_selData;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
  assign w_txPush    = w_txPushReq & (~w_txFull | w_txPop);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_txWptr <= '0;
      r_txRptr <= '0;
    end else begin
      if (w_txPush) r_txWptr <= r_txWptr + 1'b1;
      if (w_txPop)  r_txRptr <= r_txRptr + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_txPush) r_txMem[r_txWptr[PW-1:0]] <= pwdata[DATA_WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // RX FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_rxMem [FIFO_DEPTH];
  logic [PW:0]           r_rxWptr, r_rxRptr;
  logic                  w_rxEmpty, w_rxFull, w_rxPush, w_rxPopReq, w_rxPop;
  logic [DATA_WIDTH-1:0] w_rxHead;
  logic                  r_rxPushReq;
  logic [DATA_WIDTH-1:0] r_rxData;

  assign w_rxEmpty  = (r_rxWptr == r_rxRptr);
  assign w_rxFull   = (r_rxWptr[PW] != r_rxRptr[PW]) &&
                      (r_rxWptr[PW-1:0] == r_rxRptr[PW-1:0]);
  assign w_rxHead   = r_rxMem[r_rxRptr[PW-1:0]];
  assign w_rxPopReq = w_rd & w_selData;
  assign w_rxPop    = w_rxPopReq & ~w_rxEmpty;
  assign w_rxPush   = r_rxPushReq & (~w_rxFull | w_rxPop);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_rxWptr <= '0;
      r_rxRptr <= '0;
    end else begin
      if (w_rxPush) r_rxWptr <= r_rxWptr + 1'b1;
      if (w_rxPop)  r_rxRptr <= r_rxRptr + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_rxPush) r_rxMem[r_rxWptr[PW-1:0]] <= r_rxData;
  end

  // -------------------------------------------------------------------------
  // TX FSM. The divisor is latched at every bit boundary so a BAUD_DIV write
  // never stretches or truncates the bit already on the line.
  // -------------------------------------------------------------------------
  uartState_t            r_txState, w_txStateNext;
  logic [15:0]           r_txCnt, w_txCntNext;
  logic [15:0]           r_txDiv, w_txDivNext;
  logic [BW-1:0]         r_txBit, w_txBitNext;
  logic [DATA_WIDTH-1:0] r_txData;
  logic                  r_tx, w_txOutNext;
  logic                  w_txBitEnd, w_txParity, w_txBusy;

  assign w_txBitEnd = (r_txCnt == r_txDiv);
  assign w_txParity = (^r_txData) ^ w_parityOdd;
  assign w_txBusy   = (r_txState != IDLE);
  assign tx         = r_tx;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_txState <= IDLE;
      r_txCnt   <= '0;
      r_txDiv   <= RESET_DIV;
      r_txBit   <= '0;
      r_txData  <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txDiv   <= w_txDivNext;
      r_txBit   <= w_txBitNext;
      r_tx      <= w_txOutNext;
      if (w_txPop) r_txData <= w_txHead;
    end
  end

  // tx is registered from the next-state decode, so the line changes on the
  // same edge the FSM enters each state.
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 16'd1;
    w_txDivNext   = r_txDiv;
    w_txBitNext   = r_txBit;
    w_txOutNext   = r_tx;
    w_txPop       = 1'b0;
    case (r_txState)
      IDLE: begin
        w_txCntNext = '0;
        w_txDivNext = r_baudDiv;
        w_txBitNext = '0;
        w_txOutNext = 1'b1;
        if (w_txEn && !w_txEmpty) begin
          w_txPop       = 1'b1;
          w_txStateNext = START;
          w_txOutNext   = 1'b0;
        end
      end
      START: begin
        if (w_txBitEnd) begin
          w_txStateNext = DATA;
          w_txCntNext   = '0;
          w_txDivNext   = r_baudDiv;
          w_txBitNext   = '0;
          w_txOutNext   = r_txData[0];
        end
      end
      DATA: begin
        if (w_txBitEnd) begin
          w_txCntNext = '0;
          w_txDivNext = r_baudDiv;
          if (r_txBit == LAST_BIT) begin
            if (w_parityEn) begin
              w_txStateNext = PARITY;
              w_txOutNext   = w_txParity;
            end else begin
              w_txStateNext = STOP;
              w_txOutNext   = 1'b1;
            end
          end else begin
            w_txBitNext = r_txBit + BW'(1);
            w_txOutNext = r_txData[r_txBit + BW'(1)];
          end
        end
      end
      PARITY: begin
        if (w_txBitEnd) begin
          w_txStateNext = STOP;
          w_txCntNext   = '0;
          w_txDivNext   = r_baudDiv;
          w_txOutNext   = 1'b1;
        end
      end
      STOP: begin
        if (w_txBitEnd) begin
          w_txStateNext = IDLE;
          w_txCntNext   = '0;
          w_txDivNext   = r_baudDiv;
          w_txOutNext   = 1'b1;
        end
      end
      default: begin
        w_txStateNext = IDLE;
        w_txOutNext   = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // RX synchronizer and falling-edge detect
  // -------------------------------------------------------------------------
  logic r_rxSync1, r_rxSync2, r_rxPrev;
  logic w_rxLine, w_rxFall;
  assign w_rxLine = r_rxSync2;
  assign w_rxFall = r_rxPrev & ~r_rxSync2;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= rx;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  // -------------------------------------------------------------------------
  // RX FSM. START samples at half a bit; every later sample is a full bit
  // later, which lands mid-bit. A char found bad is never pushed.
  // -------------------------------------------------------------------------
  uartState_t            r_rxState, w_rxStateNext;
  logic [15:0]           r_rxCnt, w_rxCntNext;
  logic [15:0]           r_rxDiv, w_rxDivNext;
  logic [BW-1:0]         r_rxBit, w_rxBitNext;
  logic [DATA_WIDTH-1:0] w_rxDataNext;
  logic                  r_rxParBad, w_rxParBadNext;
  logic                  w_rxPushReqNext, w_parSet, w_frameSet;
  logic                  w_rxBitEnd, w_rxParityExp;

  assign w_rxBitEnd    = (r_rxCnt == r_rxDiv);
  assign w_rxParityExp = (^r_rxData) ^ w_parityOdd;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_rxState   <= IDLE;
      r_rxCnt     <= '0;
      r_rxDiv     <= RESET_DIV;
      r_rxBit     <= '0;
      r_rxData    <= '0;
      r_rxParBad  <= 1'b0;
      r_rxPushReq <= 1'b0;
    end else begin
      r_rxState   <= w_rxStateNext;
      r_rxCnt     <= w_rxCntNext;
      r_rxDiv     <= w_rxDivNext;
      r_rxBit     <= w_rxBitNext;
      r_rxData    <= w_rxDataNext;
      r_rxParBad  <= w_rxParBadNext;
      r_rxPushReq <= w_rxPushReqNext;
    end
  end

  always_comb begin
    w_rxStateNext   = r_rxState;
    w_rxCntNext     = r_rxCnt + 16'd1;
    w_rxDivNext     = r_rxDiv;
    w_rxBitNext     = r_rxBit;
    w_rxDataNext    = r_rxData;
    w_rxParBadNext  = r_rxParBad;
    w_rxPushReqNext = 1'b0;
    w_parSet        = 1'b0;
    w_frameSet      = 1'b0;
    case (r_rxState)
      IDLE: begin
        w_rxCntNext = '0;
        w_rxDivNext = r_baudDiv;
        if (w_rxEn && w_rxFall) begin
          w_rxStateNext  = START;
          w_rxParBadNext = 1'b0;
        end
      end
      START: begin
        if (r_rxCnt == (r_rxDiv >> 1)) begin
          w_rxCntNext = '0;
          w_rxDivNext = r_baudDiv;
          w_rxBitNext = '0;
          // A line already back high was only a glitch
          w_rxStateNext = w_rxLine ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_rxBitEnd) begin
          w_rxCntNext           = '0;
          w_rxDivNext           = r_baudDiv;
          w_rxDataNext[r_rxBit] = w_rxLine;
          if (r_rxBit == LAST_BIT) begin
            w_rxStateNext = w_parityEn ? PARITY : STOP;
          end else begin
            w_rxBitNext = r_rxBit + BW'(1);
          end
        end
      end
      PARITY: begin
        if (w_rxBitEnd) begin
          w_rxCntNext   = '0;
          w_rxDivNext   = r_baudDiv;
          w_rxStateNext = STOP;
          if (w_rxLine != w_rxParityExp) begin
            w_parSet       = 1'b1;
            w_rxParBadNext = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_rxBitEnd) begin
          w_rxCntNext   = '0;
          w_rxDivNext   = r_baudDiv;
          w_rxStateNext = IDLE;
          if (!w_rxLine) begin
            w_frameSet = 1'b1;
          end else if (!r_rxParBad) begin
            w_rxPushReqNext = 1'b1;
          end
        end
      end
      default: begin
        w_rxStateNext = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Register writes and sticky errors. A new error in the same cycle as a
  // write-1-to-clear wins, so no event is ever silently lost.
  // -------------------------------------------------------------------------
  logic [2:0] w_clr;
  logic       w_overSet;
  assign w_clr     = (w_wr && w_selStatus) ? pwdata[7:5] : 3'b000;
  assign w_overSet = r_rxPushReq & ~w_rxPush;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_ctrl      <= 6'h03;
      r_baudDiv   <= RESET_DIV;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr && w_selCtrl) r_ctrl    <= pwdata[5:0];
      if (w_wr && w_selBaud) r_baudDiv <= pwdata[15:0];
      r_parityErr <= (r_parityErr & ~w_clr[0]) | w_parSet;
      r_frameErr  <= (r_frameErr  & ~w_clr[1]) | w_frameSet;
      r_overrun   <= (r_overrun   & ~w_clr[2]) | w_overSet;
    end
  end

  logic [7:0] w_status;
  assign w_status = {r_overrun, r_frameErr, r_parityErr, w_txBusy,
                     w_txFull, w_txEmpty, w_rxFull, w_rxEmpty};

  // Interrupt is registered from the current flags
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_rxIrqEn & (~w_rxEmpty | r_parityErr | r_frameErr | r_overrun)) |
               (w_txIrqEn & w_txEmpty & ~w_txBusy);
    end
  end
  assign uart_irq = r_irq;

  // -------------------------------------------------------------------------
  // Read mux and error response
  // -------------------------------------------------------------------------
  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (paddr[3:2])
        2'd0:    prdata = w_rxEmpty ? 32'd0 : 32'(w_rxHead);
        2'd1:    prdata = 32'(w_status);
        2'd2:    prdata = 32'(r_ctrl);
        default: prdata = 32'(r_baudDiv);
      endcase
    end
  end

  assign pslverr = (w_txPushReq & ~w_txPush) | (w_rxPopReq & w_rxEmpty);

endmodule

// File: doc/apb_uart_fifo.md
APB_UART_FIFO -- requirements
Module: apb_uart_fifo

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 32, meaning the APB address width (only paddr[3:2] is decoded).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 8, meaning UART character bits (legal 5..8).
REQ-003 The block SHALL have the parameter FIFO_DEPTH, default 8, meaning the entries per TX/RX FIFO (power of 2, at least 2).
REQ-004 The block SHALL have the parameters CLK_FREQ_HZ, default 125000000, and BAUDRATE, default 9600, which set the reset divisor.
REQ-005 The block SHALL have the port pclk, input, 1 bit: the single clock.
REQ-006 The block SHALL have the port prst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have the APB inputs paddr [ADDR_WIDTH], pselx, penable, pwrite and pwdata [32], and the APB outputs pready, prdata [32] and pslverr.
REQ-008 The block SHALL have the port rx, input, 1 bit: serial in, asynchronous to pclk.
REQ-009 The block SHALL have the port tx, output, 1 bit: serial out, idle high.
REQ-010 The block SHALL have the port uart_irq, output, 1 bit: level interrupt.

Function
REQ-011 pready SHALL be constantly 1, giving zero-wait access; a transfer completes on the cycle with pselx&penable.
REQ-012 The register map SHALL be decoded on paddr[3:2] as follows:
- 0x0 DATA: write pushes to TX FIFO; read pops RX FIFO, char in low DATA_WIDTH bits, rest 0.
- 0x4 STATUS: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_busy, bit5 parity_err, bit6 frame_err, bit7 overrun.
- 0x8 CTRL: bit0 tx_en, bit1 rx_en, bit2 parity_en, bit3 parity_odd, bit4 rx_irq_en, bit5 tx_irq_en.
- 0xC BAUD_DIV: 16-bit; bit period = BAUD_DIV+1 pclk cycles.
REQ-013 STATUS bits 5..7 SHALL be sticky and cleared by writing 1 to the same bit (W1C); if a clear and a new error occur in the same cycle, the bit SHALL be set.
REQ-014 pslverr SHALL be 1 in the access phase for a DATA write while TX is full (data dropped) and for a DATA read while RX is empty (prdata=0, no pop); it SHALL be 0 otherwise.
REQ-015 prdata SHALL be driven combinationally during access reads and SHALL be 0 when not selected.
REQ-016 Each FIFO SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH) and wrap modulo 2*FIFO_DEPTH; full and empty SHALL both be exact.
REQ-017 A simultaneous push and pop on a FIFO SHALL leave the occupancy unchanged, including when the FIFO is full or empty.
REQ-018 The TX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, with each state other than IDLE lasting BAUD_DIV+1 cycles.
REQ-019 In IDLE with tx_en=1 and the TX FIFO non-empty, the TX FSM SHALL pop one char and the start bit SHALL appear on tx the next cycle.
REQ-020 The TX FSM SHALL send data LSB first; PARITY SHALL be sent only if parity_en (even = XOR of data bits, odd = inverted); STOP SHALL be one bit of 1.
REQ-021 tx_busy SHALL be 1 whenever the TX FSM is not in IDLE; clearing tx_en mid-frame SHALL finish the current frame and then hold in IDLE.
REQ-022 rx SHALL pass through a 2-flop synchronizer before use.
REQ-023 The RX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-024 A falling edge on the synchronized rx with rx_en=1 SHALL enter START; the line SHALL be sampled at count (BAUD_DIV>>1), and if it is high the FSM SHALL return to IDLE (glitch reject).
REQ-025 Subsequent samples SHALL be taken every BAUD_DIV+1 cycles at mid-bit.
REQ-026 On the stop sample, a received 0 SHALL set frame_err and discard the char.
REQ-027 A parity mismatch SHALL set parity_err and discard the char.
REQ-028 If the RX FIFO is full, a received char SHALL be dropped and overrun set; otherwise it SHALL be pushed one cycle after the stop sample.
REQ-029 The bit counter SHALL restart when the TX or RX FSM enters a new state.
REQ-030 Writes to BAUD_DIV SHALL take effect at the next bit boundary; BAUD_DIV=0 SHALL give 1-cycle bits.
REQ-031 uart_irq SHALL be registered and equal (rx_irq_en & (~rx_empty | parity_err | frame_err | overrun)) | (tx_irq_en & tx_empty & ~tx_busy).

Reset
REQ-032 While prst=1, the block SHALL hold: tx=1, uart_irq=0, both FIFOs empty, both FSMs IDLE, sticky bits 0, CTRL=0x03, and BAUD_DIV=CLK_FREQ_HZ/BAUDRATE-1 (integer division; 13019 at defaults).
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with tx=1 and discard FIFO contents; operation SHALL resume on the first clock after deassertion.

Verification
REQ-034 The bench SHALL cover TX: with BAUD_DIV=3 write 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles, then tx_busy=0.
REQ-035 The bench SHALL cover parity: with parity_en=1, parity_odd=0, receive 0x07 with parity bit 0 -> parity_err=1, RX FIFO stays empty; write 0x20 to STATUS -> bit5 clears.
REQ-036 The bench SHALL cover FIFO bounds: with DEPTH=8, 8 writes with tx_en=0 -> tx_full=1; a 9th write -> pslverr=1 and the FIFO is unchanged; a read of empty RX -> pslverr=1, prdata=0.
REQ-037 The bench SHALL cover overrun: receive 9 chars with no reads -> 8 stored, overrun=1, and the first char read back is the first char sent.
REQ-038 The bench SHALL cover glitch/frame errors: a 1-cycle rx low pulse -> no char and no error; a frame with stop=0 -> frame_err=1 and uart_irq=1 when rx_irq_en=1.
REQ-039 The bench SHALL cover reset: assert prst during the DATA bit -> tx=1 in the same cycle, and STATUS reads 0x05 after release.
